// File: rtl/lcompressor_pkg.sv
// rtl/lcompressor_pkg.sv - Q-format constants, clamp/saturate helpers and frame config type
package lcompressor_pkg;

    localparam logic [15:0] UNITY_Q15 = 16'h8000;
    localparam logic [15:0] UNITY_Q14 = 16'h4000;
    localparam int          FRAC      = 15;

    typedef struct packed {
        logic [15:0] threshold;
        logic [15:0] rdiff;
        logic [15:0] attack;
        logic [15:0] rel;
        logic [15:0] makeup;
        logic        bypass;
    } cfg_t;

    function automatic logic [15:0] clamp_coef(input logic [15:0] c);
        return (c > UNITY_Q15) ? UNITY_Q15 : c;
    endfunction

    function automatic logic [15:0] clamp_env(input logic signed [35:0] v);
        if (v < 36'sd0)
            return 16'h0000;
        if (v > 36'sh7FFF)
            return 16'h7FFF;
        return v[15:0];
    endfunction

    function automatic logic signed [47:0] saturate(input logic signed [47:0] v, input int bits);
        logic signed [47:0] hi;
        logic signed [47:0] lo;
        hi = (48'sd1 <<< (bits - 1)) - 48'sd1;
        lo = -(48'sd1 <<< (bits - 1));
        if (v > hi)
            return hi;
        if (v < lo)
            return lo;
        return v;
    endfunction

endpackage

// File: rtl/lcomp_gain_calc.sv
// rtl/lcomp_gain_calc.sv - combinational compression gain law (env over threshold scaled by rdiff)
module lcomp_gain_calc
    import lcompressor_pkg::*;
(
    input  logic [15:0] env,
    input  logic [15:0] threshold,
    input  logic [15:0] rdiff,
    input  logic        bypass,
    output logic [15:0] gain
);

    logic [15:0] diff;
    logic [31:0] prod;
    logic [16:0] depth;

    always_comb begin
        diff  = env - threshold;
        prod  = 32'(diff) * 32'(rdiff);
        depth = 17'(prod >> FRAC);
        gain  = UNITY_Q15;
        if (!bypass && env > threshold)
            gain = (depth >= 17'(UNITY_Q15)) ? 16'h0000 : 16'(17'(UNITY_Q15) - depth);
    end

endmodule

// File: rtl/lcompressor_mc.sv
// rtl/lcompressor_mc.sv - time-multiplexed multi-channel peak compressor, fixed 5-cycle pipeline
module lcompressor_mc
    import lcompressor_pkg::*;
#(
    parameter int          W_DATA        = 16,
    parameter int          NUM_CH        = 2,
    parameter int          CH_W          = 1,
    parameter logic [15:0] DEF_THRESHOLD = 16'h4000,
    parameter logic [15:0] DEF_RDIFF     = 16'h6000,
    parameter logic [15:0] DEF_ATTACK    = 16'h1000,
    parameter logic [15:0] DEF_RELEASE   = 16'h0050,
    parameter logic [15:0] DEF_MAKEUP    = 16'h4000
) (
    input  logic                     i_clk,
    input  logic                     i_reset_n,
    input  logic                     i_ce,
    input  logic [CH_W-1:0]          i_ch,
    input  logic signed [W_DATA-1:0] i_data,
    input  logic [15:0]              i_threshold,
    input  logic [15:0]              i_rdiff,
    input  logic [15:0]              i_attack,
    input  logic [15:0]              i_release,
    input  logic [15:0]              i_makeup,
    input  logic                     i_bypass,
    output logic [W_DATA-1:0]        o_data,
    output logic [CH_W-1:0]          o_ch,
    output logic                     o_ce,
    output logic [15:0]              o_gain,
    output logic                     o_clip
);

    localparam int PW = W_DATA + 17;
    localparam int QW = W_DATA + 2;
    localparam int OW = W_DATA + 19;
    localparam logic [W_DATA-1:0] MAX_POS = {1'b0, {(W_DATA-1){1'b1}}};
    localparam logic [W_DATA-1:0] MIN_NEG = {1'b1, {(W_DATA-1){1'b0}}};

    cfg_t              shadow, cfg_in, cfg_eff;
    logic [W_DATA-1:0] mag_w;
    logic [15:0]       env [NUM_CH];

    logic                     s1_valid, s2_valid, s3_valid, s4_valid;
    logic [CH_W-1:0]          s1_ch, s2_ch, s3_ch, s4_ch;
    logic signed [W_DATA-1:0] s1_data, s2_data, s3_data;
    logic [15:0]              s1_mag;
    cfg_t                     s1_cfg;
    logic [15:0]              s2_env, s2_thr, s2_rdiff, s2_makeup, s3_makeup, s4_makeup;
    logic                     s2_inrange, s2_bypass, s3_bypass;
    logic [15:0]              s3_gain, s4_gain, gain_raw;
    logic signed [QW-1:0]     s4_prod;

    logic               s1_inrange;
    logic [15:0]        env_cur, coef, env_new;
    logic signed [16:0] delta;
    logic signed [33:0] step;
    logic signed [PW-1:0] p4;
    logic signed [OW-1:0] p5;
    logic signed [47:0]   r5, sat;

    // A channel-0 sample both latches the new frame config and is processed with it.
    always_comb begin
        cfg_in.threshold = i_threshold;
        cfg_in.rdiff     = clamp_coef(i_rdiff);
        cfg_in.attack    = clamp_coef(i_attack);
        cfg_in.rel       = clamp_coef(i_release);
        cfg_in.makeup    = i_makeup;
        cfg_in.bypass    = i_bypass;
        cfg_eff = (i_ce && i_ch == '0) ? cfg_in : shadow;
        if (i_data == MIN_NEG)
            mag_w = MAX_POS;
        else if (i_data[W_DATA-1])
            mag_w = -i_data;
        else
            mag_w = i_data;
    end

    always_comb begin
        s1_inrange = int'(s1_ch) < NUM_CH;
        env_cur    = s1_inrange ? env[s1_ch] : 16'h0000;
        coef       = (s1_mag > env_cur) ? s1_cfg.attack : s1_cfg.rel;
        delta      = $signed({1'b0, s1_mag}) - $signed({1'b0, env_cur});
        step       = 34'(delta) * 34'($signed({1'b0, coef}));
        env_new    = clamp_env(36'(step >>> FRAC) + 36'($signed({1'b0, env_cur})));
        p4         = PW'(s3_data) * PW'($signed({1'b0, s3_gain}));
        p5         = OW'(s4_prod) * OW'($signed({1'b0, s4_makeup}));
        r5         = 48'(p5 >>> (FRAC - 1));
        sat        = saturate(r5, W_DATA);
    end

    lcomp_gain_calc u_gain (
        .env       (s2_env),
        .threshold (s2_thr),
        .rdiff     (s2_rdiff),
        .bypass    (s2_bypass),
        .gain      (gain_raw)
    );

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            shadow.threshold <= DEF_THRESHOLD;
            shadow.rdiff     <= clamp_coef(DEF_RDIFF);
            shadow.attack    <= clamp_coef(DEF_ATTACK);
            shadow.rel       <= clamp_coef(DEF_RELEASE);
            shadow.makeup    <= DEF_MAKEUP;
            shadow.bypass    <= 1'b0;
            for (int i = 0; i < NUM_CH; i++)
                env[i] <= 16'h0000;
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s3_valid <= 1'b0;
            s4_valid <= 1'b0;
        end else begin
            if (i_ce && i_ch == '0)
                shadow <= cfg_in;
            if (s1_valid && s1_inrange)
                env[s1_ch] <= env_new;
            s1_valid <= i_ce;
            s2_valid <= s1_valid;
            s3_valid <= s2_valid;
            s4_valid <= s3_valid;
        end
    end

    // Datapath registers carry no reset; only the valids qualify them.
    always_ff @(posedge i_clk) begin
        s1_ch      <= i_ch;
        s1_data    <= i_data;
        s1_mag     <= 16'((48'(mag_w) << 16) >> W_DATA);
        s1_cfg     <= cfg_eff;
        s2_ch      <= s1_ch;
        s2_data    <= s1_data;
        s2_env     <= env_new;
        s2_inrange <= s1_inrange;
        s2_thr     <= s1_cfg.threshold;
        s2_rdiff   <= s1_cfg.rdiff;
        s2_makeup  <= s1_cfg.makeup;
        s2_bypass  <= s1_cfg.bypass;
        s3_ch      <= s2_ch;
        s3_data    <= s2_data;
        s3_gain    <= s2_inrange ? gain_raw : UNITY_Q15;
        s3_makeup  <= s2_makeup;
        s3_bypass  <= s2_bypass;
        s4_ch      <= s3_ch;
        s4_gain    <= s3_gain;
        s4_prod    <= QW'(p4 >>> FRAC);
        s4_makeup  <= s3_bypass ? UNITY_Q14 : s3_makeup;
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            o_ce   <= 1'b0;
            o_data <= '0;
            o_ch   <= '0;
            o_gain <= UNITY_Q15;
            o_clip <= 1'b0;
        end else begin
            o_ce <= s4_valid;
            if (s4_valid) begin
                o_data <= sat[W_DATA-1:0];
                o_ch   <= s4_ch;
                o_gain <= s4_gain;
                o_clip <= (sat != r5);
            end
        end
    end

endmodule

// File: tb/tb_lcompressor_mc.sv
// tb/tb_lcompressor_mc.sv - self-checking bench for lcompressor_mc against an arithmetic model
module tb_lcompressor_mc;

    localparam int NCH = 3;

    logic               i_clk = 1'b0;
    logic               i_reset_n, i_ce, i_bypass;
    logic [1:0]         i_ch;
    logic signed [15:0] i_data;
    logic [15:0]        i_threshold, i_rdiff, i_attack, i_release, i_makeup;
    logic [15:0]        o_data, o_gain;
    logic [1:0]         o_ch;
    logic               o_ce, o_clip;

    always #5 i_clk = ~i_clk;

    lcompressor_mc #(.W_DATA(16), .NUM_CH(NCH), .CH_W(2)) dut (
        .i_clk       (i_clk),
        .i_reset_n   (i_reset_n),
        .i_ce        (i_ce),
        .i_ch        (i_ch),
        .i_data      (i_data),
        .i_threshold (i_threshold),
        .i_rdiff     (i_rdiff),
        .i_attack    (i_attack),
        .i_release   (i_release),
        .i_makeup    (i_makeup),
        .i_bypass    (i_bypass),
        .o_data      (o_data),
        .o_ch        (o_ch),
        .o_ce        (o_ce),
        .o_gain      (o_gain),
        .o_clip      (o_clip)
    );

    typedef struct {
        longint      due;
        logic [15:0] data;
        logic [1:0]  ch;
        logic [15:0] gain;
        logic        clip;
    } exp_t;

    int     total = 0;
    int     bad   = 0;
    longint cyc   = 0;
    bit     mon_on = 0;
    exp_t   q[$];
    exp_t   last;
    longint env_m [NCH];
    longint sh_thr, sh_rdiff, sh_att, sh_rel, sh_mk;
    bit     sh_byp;
    int     c_thr, c_rd, c_att, c_rel, c_mk;
    bit     c_byp;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic longint clc(input int c);
        return (c > 32768) ? 64'sd32768 : longint'(c);
    endfunction

    task automatic model_reset();
        q.delete();
        for (int i = 0; i < NCH; i++) env_m[i] = 0;
        sh_thr = 16384; sh_rdiff = 24576; sh_att = 4096; sh_rel = 80; sh_mk = 16384; sh_byp = 0;
        last.due = 0; last.data = 16'h0; last.ch = 2'd0; last.gain = 16'h8000; last.clip = 1'b0;
    endtask

    // Output due 5 cycles after the cycle in which the sample is presented.
    task automatic model(input int ch, input int data);
        longint d, mag, e, coef, g, p, mkv, o;
        logic [15:0] dbits;
        exp_t x;
        if (ch == 0) begin
            sh_thr = c_thr; sh_rdiff = clc(c_rd); sh_att = clc(c_att);
            sh_rel = clc(c_rel); sh_mk = c_mk; sh_byp = c_byp;
        end
        dbits = data[15:0];
        d = longint'($signed(dbits));
        mag = (d < 0) ? -d : d;
        if (mag > 32767) mag = 32767;
        g = 32768;
        if (ch < NCH) begin
            e = env_m[ch];
            coef = (mag > e) ? sh_att : sh_rel;
            e = e + (((mag - e) * coef) >>> 15);
            if (e < 0) e = 0;
            if (e > 32767) e = 32767;
            env_m[ch] = e;
            if (!sh_byp && e > sh_thr) begin
                g = 32768 - (((e - sh_thr) * sh_rdiff) >>> 15);
                if (g < 0) g = 0;
            end
        end
        p = (d * g) >>> 15;
        mkv = sh_byp ? 64'sd16384 : sh_mk;
        o = (p * mkv) >>> 14;
        x.clip = (o > 32767) || (o < -32768);
        if (o > 32767) o = 32767;
        if (o < -32768) o = -32768;
        x.due = cyc + 5; x.data = o[15:0]; x.ch = ch[1:0]; x.gain = g[15:0];
        q.push_back(x);
    endtask

    task automatic s(input bit ce, input int ch, input int data);
        @(negedge i_clk); #2;
        i_ce = ce; i_ch = ch[1:0]; i_data = data[15:0];
        i_threshold = c_thr[15:0]; i_rdiff = c_rd[15:0]; i_attack = c_att[15:0];
        i_release = c_rel[15:0]; i_makeup = c_mk[15:0]; i_bypass = c_byp;
        if (ce) model(ch, data);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) s(1'b0, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge i_clk); #2;
        i_reset_n = 1'b0; i_ce = 1'b0;
        model_reset();
        @(negedge i_clk); #2;
        i_reset_n = 1'b1;
    endtask

    task automatic pin(input string nm, input logic [15:0] g, input logic [15:0] d, input logic c);
        chk({nm, "_gain"}, q[$].gain, g);
        chk({nm, "_data"}, q[$].data, d);
        chk({nm, "_clip"}, q[$].clip, c);
    endtask

    always @(negedge i_clk) begin
        if (mon_on) begin
            bit exp_ce;
            exp_ce = (q.size() > 0) && (q[0].due == cyc);
            chk("o_ce", o_ce, exp_ce);
            if (exp_ce) last = q.pop_front();
            chk("o_data", o_data, last.data);
            chk("o_ch", o_ch, last.ch);
            chk("o_gain", o_gain, last.gain);
            chk("o_clip", o_clip, last.clip);
        end
    end

    initial begin
        i_reset_n = 1'b0; i_ce = 1'b0; i_ch = 2'd0; i_data = '0; i_bypass = 1'b0;
        c_thr = 'h4000; c_rd = 'h6000; c_att = 'h1000; c_rel = 'h0050; c_mk = 'h4000; c_byp = 0;
        i_threshold = 16'h4000; i_rdiff = 16'h6000; i_attack = 16'h1000;
        i_release = 16'h0050; i_makeup = 16'h4000;
        model_reset();
        repeat (2) @(negedge i_clk);
        #2 i_reset_n = 1'b1;
        mon_on = 1;
        chk("rst_ce", o_ce, 1'b0);
        chk("rst_gain", o_gain, 16'h8000);
        chk("rst_data", o_data, 16'h0000);

        for (int i = 0; i < 6; i++) s(1'b1, 0, 'h1000);
        pin("default", 16'h8000, 16'h1000, 1'b0);
        idle(6);

        c_att = 'h8000; c_rel = 'h0800;
        s(1'b1, 0, 'h6000);  pin("attack", 16'h6800, 16'h4E00, 1'b0);
        s(1'b1, 0, 'hA000);  pin("negative", 16'h6800, 16'hB200, 1'b0);
        s(1'b1, 0, 'h0000);  pin("release", 16'h6C80, 16'h0000, 1'b0);
        c_mk = 'h8000;
        s(1'b1, 0, 'h6000);  pin("clip", 16'h6800, 16'h7FFF, 1'b1);
        c_mk = 'h4000;
        s(1'b1, 0, 'h8000);  pin("minneg", 16'h5001, 16'hAFFF, 1'b0);

        for (int i = 0; i < 3; i++) begin
            s(1'b1, 0, 'h6000);
            s(1'b1, 1, 'h1000);
        end
        pin("ch1", 16'h8000, 16'h1000, 1'b0);
        s(1'b1, 0, 'h6000);
        c_thr = 'h0000;
        s(1'b1, 1, 'h1000);  pin("midframe", 16'h8000, 16'h1000, 1'b0);
        s(1'b1, 0, 'h1000);
        c_thr = 'h4000;
        s(1'b1, 3, 'h6000);  pin("oor", 16'h8000, 16'h6000, 1'b0);
        c_byp = 1;
        s(1'b1, 0, 'h6000);  pin("bypass", 16'h8000, 16'h6000, 1'b0);
        c_byp = 0;
        idle(6);

        s(1'b1, 0, 'h7000); s(1'b1, 1, 'h7000); s(1'b1, 0, 'h7000);
        do_reset();
        idle(8);
        chk("rst2_ce", o_ce, 1'b0);
        chk("rst2_gain", o_gain, 16'h8000);
        c_att = 'h1000; c_rel = 'h0800;
        s(1'b1, 0, 'h6000);  pin("envzero", 16'h8000, 16'h6000, 1'b0);
        idle(6);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) do_reset();
            c_thr = int'($urandom_range(0, 65535));
            c_rd  = int'($urandom_range(0, 32768));
            c_att = int'($urandom_range(0, 65535));
            c_rel = int'($urandom_range(0, 65535));
            c_mk  = int'($urandom_range(0, 32768));
            c_byp = ($urandom_range(0, 7) == 0);
            s($urandom_range(0, 3) != 0, int'($urandom_range(0, 3)), int'($urandom_range(0, 65535)));
        end
        idle(10);
        chk("drain", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
